// File: rtl/level_debounce_pkg.sv
// rtl/level_debounce_pkg.sv - shared types and sizing helpers for the level switch debouncer
package level_debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chan_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  // Counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one switch channel: input synchroniser, saturating counter and STABLE/PENDING FSM
module debounce_channel
  import level_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic update
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  chan_state_t            r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_update;

  chan_state_t            w_state_next;
  logic [CW-1:0]          w_cnt_next;
  logic                   w_level_next;
  logic                   w_update_next;
  logic                   w_sync;
  logic                   w_mismatch;

  // Plain flop chain: nothing may sit between metastability stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync ^ r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= STABLE;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_level  <= w_level_next;
      r_update <= w_update_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STABLE: begin
        if (w_mismatch) w_state_next = PENDING;
      end
      PENDING: begin
        if (!w_mismatch || (r_cnt == CNT_MAX)) w_state_next = STABLE;
      end
      default: w_state_next = STABLE;
    endcase
  end

  // Counter only advances below CNT_MAX, so it saturates rather than wraps.
  always_comb begin
    w_cnt_next    = '0;
    w_level_next  = r_level;
    w_update_next = 1'b0;
    case (r_state)
      STABLE: begin
        if (w_mismatch) w_cnt_next = CW'(1);
      end
      PENDING: begin
        if (w_mismatch) begin
          if (r_cnt == CNT_MAX) begin
            w_level_next  = w_sync;
            w_update_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: w_cnt_next = '0;
    endcase
  end

  assign level  = r_level;
  assign update = r_update;

endmodule

// File: rtl/level_debouncer.sv
// rtl/level_debouncer.sv - WIDTH-channel switch debouncer with change pulse; LEVEL_DEBOUNCE_MASK_EN adds change_mask
module level_debouncer
  import level_debounce_pkg::*;
#(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] levels,
  output logic             level_change
`ifdef LEVEL_DEBOUNCE_MASK_EN
  ,
  output logic [WIDTH-1:0] change_mask
`endif
);

  logic [WIDTH-1:0] w_levels;
  logic [WIDTH-1:0] w_update;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (sw_raw[gi]),
      .level  (w_levels[gi]),
      .update (w_update[gi])
    );
  end

  // Update bits are flops aligned with levels, so the OR yields one pulse per event.
  assign levels       = w_levels;
  assign level_change = |w_update;

`ifdef LEVEL_DEBOUNCE_MASK_EN
  assign change_mask = w_update;
`endif

endmodule

// File: tb/tb_level_debouncer.sv
// tb/tb_level_debouncer.sv - self-checking bench for level_debouncer (DEBOUNCE_CYCLES 4 and 1 instances)
module tb_level_debouncer;

  localparam int W      = 6;
  localparam int S      = 2;
  localparam int D_MAIN = 4;
  localparam int D_FAST = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_raw1;
  logic [W-1:0] levels;
  logic [W-1:0] levels1;
  logic         level_change;
  logic         level_change1;
`ifdef LEVEL_DEBOUNCE_MASK_EN
  logic [W-1:0] change_mask;
  logic [W-1:0] change_mask1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: raw delayed S edges, then "last D+1 synced samples all differ from level".
  logic [W-1:0] m_raw_q [2][$];
  logic [W-1:0] m_win   [2][$];
  logic [W-1:0] m_lev   [2];
  logic [W-1:0] m_upd   [2];

  level_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D_MAIN), .SYNC_STAGES(S)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_raw       (sw_raw),
    .levels       (levels),
    .level_change (level_change)
`ifdef LEVEL_DEBOUNCE_MASK_EN
    ,
    .change_mask  (change_mask)
`endif
  );

  level_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D_FAST), .SYNC_STAGES(S)) u_dut_fast (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_raw       (sw_raw1),
    .levels       (levels1),
    .level_change (level_change1)
`ifdef LEVEL_DEBOUNCE_MASK_EN
    ,
    .change_mask  (change_mask1)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_raw_q[k] = {};
      for (int j = 0; j < S; j++) m_raw_q[k].push_back('0);
      m_win[k] = {};
      m_lev[k] = '0;
      m_upd[k] = '0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] fsm_in;
    logic [W-1:0] raw;
    int           span;
    bit           all_diff;
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      span   = ((k == 0) ? D_MAIN : D_FAST) + 1;
      raw    = (k == 0) ? sw_raw : sw_raw1;
      fsm_in = m_raw_q[k].pop_front();
      m_raw_q[k].push_back(raw);
      m_win[k].push_back(fsm_in);
      if (m_win[k].size() > span) void'(m_win[k].pop_front());
      m_upd[k] = '0;
      if (m_win[k].size() == span) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < span; j++)
            if (m_win[k][j][i] == m_lev[k][i]) all_diff = 1'b0;
          m_upd[k][i] = all_diff;
        end
      end
      m_lev[k] = m_lev[k] ^ m_upd[k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    sw_raw  = '1;
    sw_raw1 = '0;
    rst_n   = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (levels !== '0 || level_change !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold: levels=%b change=%b required levels=000000 change=0", levels, level_change);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_checks++;
      if (levels !== ((c == 7) ? 6'b111111 : 6'b000000) || level_change !== (c == 7)) begin
        n_errors++;
        $display("FAIL reset_release c=%0d: levels=%b change=%b required levels=%b change=%0d",
                 c, levels, level_change, (c == 7) ? 6'b111111 : 6'b000000, (c == 7));
      end
`ifdef LEVEL_DEBOUNCE_MASK_EN
      n_checks++;
      if (change_mask !== ((c == 7) ? 6'b111111 : 6'b000000)) begin
        n_errors++;
        $display("FAIL reset_release_mask c=%0d: mask=%b", c, change_mask);
      end
`endif
    end
    tick();
    n_checks++;
    if (level_change !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_single_pulse: change=%b required 0", level_change);
    end
    sw_raw = '0;
    for (int c = 0; c < 8; c++) tick();
    n_checks++;
    if (levels !== '0) begin
      n_errors++;
      $display("FAIL settle_low: levels=%b required 000000", levels);
    end
  endtask

  task automatic test_single_rise();
    sw_raw[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (levels !== ((c >= 7) ? 6'b000001 : 6'b000000) || level_change !== (c == 7)) begin
        n_errors++;
        $display("FAIL single_rise c=%0d: levels=%b change=%b required levels=%b change=%0d",
                 c, levels, level_change, (c >= 7) ? 6'b000001 : 6'b000000, (c == 7));
      end
`ifdef LEVEL_DEBOUNCE_MASK_EN
      n_checks++;
      if (change_mask !== ((c == 7) ? 6'b000001 : 6'b000000)) begin
        n_errors++;
        $display("FAIL single_rise_mask c=%0d: mask=%b", c, change_mask);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    for (int p = 0; p < 5; p++) begin
      sw_raw[3] = (p < 4) ? ~p[0] : 1'b0;
      for (int c = 0; c < ((p < 4) ? 2 : 10); c++) begin
        tick();
        n_checks++;
        if (levels !== 6'b000001 || level_change !== 1'b0) begin
          n_errors++;
          $display("FAIL bounce p=%0d: levels=%b change=%b required levels=000001 change=0",
                   p, levels, level_change);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    sw_raw[1] = 1'b1;
    sw_raw[5] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (levels !== ((c >= 7) ? 6'b100011 : 6'b000001) || level_change !== (c == 7)) begin
        n_errors++;
        $display("FAIL simultaneous c=%0d: levels=%b change=%b required levels=%b change=%0d",
                 c, levels, level_change, (c >= 7) ? 6'b100011 : 6'b000001, (c == 7));
      end
`ifdef LEVEL_DEBOUNCE_MASK_EN
      n_checks++;
      if (change_mask !== ((c == 7) ? 6'b100010 : 6'b000000)) begin
        n_errors++;
        $display("FAIL simultaneous_mask c=%0d: mask=%b required %b", c, change_mask,
                 (c == 7) ? 6'b100010 : 6'b000000);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_pending();
    sw_raw[2] = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (levels !== '0 || level_change !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_pending_reset: levels=%b change=%b required levels=000000 change=0",
               levels, level_change);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (levels !== '0 || level_change !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_pending_hold: levels=%b change=%b", levels, level_change);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_checks++;
      if (levels !== ((c == 7) ? 6'b100111 : 6'b000000) || level_change !== (c == 7)) begin
        n_errors++;
        $display("FAIL mid_pending_release c=%0d: levels=%b change=%b required levels=%b change=%0d",
                 c, levels, level_change, (c == 7) ? 6'b100111 : 6'b000000, (c == 7));
      end
    end
  endtask

  task automatic test_short_debounce();
    sw_raw1[4] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++;
      if (levels1 !== ((c >= 4) ? 6'b010000 : 6'b000000) || level_change1 !== (c == 4)) begin
        n_errors++;
        $display("FAIL fast_step c=%0d: levels=%b change=%b required levels=%b change=%0d",
                 c, levels1, level_change1, (c >= 4) ? 6'b010000 : 6'b000000, (c == 4));
      end
    end
    sw_raw1[4] = 1'b0;
    tick();
    sw_raw1[4] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (levels1 !== 6'b010000 || level_change1 !== 1'b0) begin
        n_errors++;
        $display("FAIL fast_glitch c=%0d: levels=%b change=%b required levels=010000 change=0",
                 c, levels1, level_change1);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) sw_raw  = sw_raw  ^ (W'($urandom) & W'($urandom) & W'($urandom));
      if ($urandom_range(0, 3) == 0) sw_raw1 = sw_raw1 ^ (W'($urandom) & W'($urandom) & W'($urandom));
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      if (!rst_n) model_reset();
      tick();
      n_checks++;
      if (levels !== m_lev[0] || level_change !== (|m_upd[0])) begin
        n_errors++;
        $display("FAIL random_main n=%0d: levels=%b change=%b required levels=%b change=%b",
                 n, levels, level_change, m_lev[0], |m_upd[0]);
      end
      n_checks++;
      if (levels1 !== m_lev[1] || level_change1 !== (|m_upd[1])) begin
        n_errors++;
        $display("FAIL random_fast n=%0d: levels=%b change=%b required levels=%b change=%b",
                 n, levels1, level_change1, m_lev[1], |m_upd[1]);
      end
`ifdef LEVEL_DEBOUNCE_MASK_EN
      n_checks++;
      if (change_mask !== m_upd[0] || change_mask1 !== m_upd[1]) begin
        n_errors++;
        $display("FAIL random_mask n=%0d: masks=%b/%b required %b/%b",
                 n, change_mask, change_mask1, m_upd[0], m_upd[1]);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_bounce();
    test_simultaneous();
    test_reset_mid_pending();
    test_short_debounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
